demux_dispatch: RTL and testbench



---
 rtl/demux_dispatch.sv | 110 +++++++++++
 tb/tb_demux_dispatch.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch.sv
// demux_dispatch: one-entry holding register in front of a 1-to-N demux.
// Words arrive on a valid/ready stream and are presented one at a time with a
// round-robin channel select. Dispatch is strictly in order: the held word
// waits for its own channel's ready, and channels are never skipped.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   clear      synchronous flush: drops the held word, pointer back to 0
//   in_valid   upstream word valid
//   in_ready   block can take a word this cycle
//   in_data    upstream word (WIRE bits)
//   ctrl       channel select of the held word (feeds demux ctrl)
//   data       held word (feeds demux in)
//   out_valid  one-hot per-channel valid, bit ctrl set while holding a word
//   out_ready  per-channel consumer ready
//   count      words dispatched, wraps modulo 2**(SIZE_CTRL+8)
module demux_dispatch #(
  parameter int SIZE_CTRL = 2,
  parameter int WIRE      = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIRE-1:0]        in_data,
  output logic [SIZE_CTRL-1:0]   ctrl,
  output logic [WIRE-1:0]        data,
  output logic [2**SIZE_CTRL-1:0] out_valid,
  input  logic [2**SIZE_CTRL-1:0] out_ready,
  output logic [SIZE_CTRL+7:0]   count
);

  localparam int N  = 2**SIZE_CTRL;
  localparam int CW = SIZE_CTRL + 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SIZE_CTRL-1:0] ptr_q,   ptr_d;
  logic [WIRE-1:0]      data_q,  data_d;
  logic [CW-1:0]        count_q, count_d;

  logic full;
  logic fire;
  logic accept;

  assign full = (state_q == FULL);

  // Only the target channel's ready matters; other channels never fire.
  assign fire = full & out_ready[ptr_q];

  // Ready passes straight through from the consumer so a word can be
  // replaced in the same cycle it leaves. Held low while flushing.
  assign in_ready = ~clear & (~full | fire);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    count_d = count_q;
    if (clear) begin
      state_d = EMPTY;
      ptr_d   = '0;
    end else begin
      if (fire) begin
        state_d = EMPTY;
        ptr_d   = ptr_q + SIZE_CTRL'(1);
        count_d = count_q + CW'(1);
      end
      // A new word overrides the EMPTY transition when one leaves and one
      // arrives on the same edge.
      if (accept) begin
        state_d = FULL;
        data_d  = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    out_valid = '0;
    for (int unsigned i = 0; i < N; i++) begin
      out_valid[i] = full && (ptr_q == SIZE_CTRL'(i));
    end
  end

  assign ctrl  = ptr_q;
  assign data  = data_q;
  assign count = count_q;

endmodule

// File: tb/tb_demux_dispatch.sv
module tb_demux_dispatch;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [0:0] in_data;
  logic [1:0] ctrl;
  logic [0:0] data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [9:0] count;

  int checks = 0;
  int errors = 0;

  demux_dispatch #(.SIZE_CTRL(2), .WIRE(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ctrl      (ctrl),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 1'b0;
    out_ready = 4'b0000;

    // Reset values
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_ctrl",      32'(ctrl),      32'h0);
    chk("rst_count",     32'(count),     32'h0);
    chk("rst_data",      32'(data),      32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    #9;
    reset = 1'b0;

    // Round-robin sweep with all consumers ready
    in_valid  = 1'b1;
    in_data   = 1'b1;
    out_ready = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      edge1();
      chk("rr_out_valid", 32'(out_valid), 32'(4'b0001 << (k % 4)));
      chk("rr_ctrl",      32'(ctrl),      32'(k % 4));
      chk("rr_count",     32'(count),     32'(k));
      chk("rr_in_ready",  32'(in_ready),  32'h1);
      chk("rr_data",      32'(data),      32'h1);
    end
    // full, ptr=1, count=5

    // Upstream goes idle: held word drains, pointer advances and holds
    in_valid = 1'b0;
    in_data  = 1'bx;
    edge1();
    chk("drain_out_valid", 32'(out_valid), 32'h0);
    chk("drain_ctrl",      32'(ctrl),      32'h2);
    chk("drain_count",     32'(count),     32'h6);
    edge1();
    chk("idle_out_valid", 32'(out_valid), 32'h0);
    chk("idle_ctrl",      32'(ctrl),      32'h2);
    chk("idle_count",     32'(count),     32'h6);
    chk("idle_in_ready",  32'(in_ready),  32'h1);

    // Word for channel 2 stalls while only the other channels are ready
    in_valid  = 1'b1;
    in_data   = 1'b1;
    out_ready = 4'b1011;
    edge1();
    in_data = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("stall_out_valid", 32'(out_valid), 32'h4);
      chk("stall_ctrl",      32'(ctrl),      32'h2);
      chk("stall_count",     32'(count),     32'h6);
      chk("stall_in_ready",  32'(in_ready),  32'h0);
      chk("stall_data",      32'(data),      32'h1);
      edge1();
    end
    out_ready = 4'b1111;
    in_valid  = 1'b0;
    #1;
    chk("unstall_in_ready", 32'(in_ready), 32'h1);
    edge1();
    chk("unstall_ctrl",      32'(ctrl),      32'h3);
    chk("unstall_out_valid", 32'(out_valid), 32'h0);
    chk("unstall_count",     32'(count),     32'h7);

    // Clear while holding a word at channel 3
    in_valid  = 1'b1;
    in_data   = 1'b1;
    out_ready = 4'b0000;
    edge1();
    chk("pre_clr_out_valid", 32'(out_valid), 32'h8);
    clear = 1'b1;
    #1;
    chk("clr_in_ready", 32'(in_ready), 32'h0);
    edge1();
    chk("clr_out_valid", 32'(out_valid), 32'h0);
    chk("clr_ctrl",      32'(ctrl),      32'h0);
    chk("clr_count",     32'(count),     32'h7);
    clear = 1'b0;

    // Alternating data across channels 0..3 with no bubbles
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      in_data = (k % 2 == 0) ? 1'b1 : 1'b0;
      edge1();
      chk("alt_ctrl",      32'(ctrl),      32'(k));
      chk("alt_data",      32'(data),      32'((k % 2 == 0) ? 1 : 0));
      chk("alt_out_valid", 32'(out_valid), 32'(4'b0001 << k));
      chk("alt_count",     32'(count),     32'(7 + k));
      chk("alt_in_ready",  32'(in_ready),  32'h1);
    end
    // full at ctrl=3, count=10

    // Asynchronous reset mid-cycle while full
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_ctrl",      32'(ctrl),      32'h0);
    chk("arst_count",     32'(count),     32'h0);
    chk("arst_data",      32'(data),      32'h0);
    edge1();
    #2;
    reset = 1'b0;

    // Count wrap: one accept edge then 1028 fires
    in_valid  = 1'b1;
    in_data   = 1'b1;
    out_ready = 4'b1111;
    edge1();
    chk("wrap_start_count", 32'(count), 32'h0);
    for (int k = 0; k < 1023; k++) edge1();
    chk("wrap_max_count", 32'(count), 32'h3ff);
    edge1();
    chk("wrap_zero_count", 32'(count), 32'h0);
    for (int k = 0; k < 4; k++) edge1();
    chk("wrap_final_count",     32'(count),     32'h4);
    chk("wrap_final_ctrl",      32'(ctrl),      32'h0);
    chk("wrap_final_out_valid", 32'(out_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
